aes_genkey_arbiter: RTL and testbench
=====================================

// Module: aes_genkey_arbiter
// PURPOSE
//  Shares one aes_genkey round-key expansion engine between NREQ hash cores.
//  Round-robin grants one requester, latches its 256-bit key, and pulses the
//  engine's rstn to restart it. Waits for keygen_done, then streams round keys
//  k0..k9 to the granted core, one per valid/ready handshake.
//  Sits between the per-core CryptoNight scratchpad init logic and the single
//  shared aes_genkey instance.
// PARAMETERS
//  NREQ     4   number of requesters (1..8)
//  TIMEOUT  16  max cycles from engine release to eng_done before error
// PORTS
//  clk        in   1         clock
//  rstn       in   1         async active-low reset
//  req        in   NREQ      request, one bit per core; held until rk_last accepted
//  key_in     in   NREQ*256  per-core key; slice i = {input1,input0} of core i
//  gnt        out  NREQ      one-hot grant, high from grant until stream end/abort
//  rk_valid   out  1         round key valid
//  rk_ready   in   1         granted core accepts round key
//  rk_idx     out  4         round key index 0..9
//  rk_data    out  128       round key
//  rk_last    out  1         rk_idx==9 qualifier
//  err        out  1         one-cycle pulse: engine timeout
//  err_id     out  3         requester index for the err pulse (valid with err)
//  eng_rstn   out  1         engine reset, active low
//  eng_in0    out  128       engine input0 (latched key[127:0])
//  eng_in1    out  128       engine input1 (latched key[255:128])
//  eng_done   in   1         engine keygen_done
//  eng_k      in   1280      engine {k9..k0}, k0 at [127:0]
// BEHAVIOUR
//  Reset (async, rstn=0): state=IDLE, gnt=0, rk_valid=0, rk_idx=0, rk_data=0,
//   rk_last=0, err=0, err_id=0, eng_rstn=0, eng_in0/1=0, rr pointer=0.
//  eng_rstn is held 0 in every state except WAIT and STREAM.
//  IDLE: if |req, pick the first set bit at or after the rr pointer (wrapping).
//   Set gnt, latch key slice into eng_in0/eng_in1, go to RST.
//   The rr pointer becomes the winner+1 mod NREQ.
//  RST: exactly one cycle with eng_rstn=0, key stable; go to WAIT.
//  WAIT: eng_rstn=1. A timer counts cycles from 0.
//   - eng_done=1: go to STREAM with rk_idx=0.
//   - Timer reaches TIMEOUT: pulse err and err_id=granted index, drop gnt,
//     go to IDLE.
//   Nominal engine latency is 6 cycles.
//  STREAM: rk_valid=1, rk_data=eng_k[rk_idx*128+:128], rk_last=(rk_idx==9).
//   - On rk_valid&rk_ready: rk_idx++.
//   - On the handshake with rk_last: go to IDLE; gnt, rk_valid and rk_idx clear
//     the next cycle.
//   - rk_data and rk_idx are stable while rk_valid&!rk_ready.
//  Abort: if req[granted] falls in RST/WAIT/STREAM, go to IDLE the next cycle.
//   gnt and rk_valid drop, no err. Any pending beat is dropped.
//  Arbitration occurs only in IDLE. New requests during a grant wait.
//   The earliest re-grant is the cycle after return to IDLE.
//  A requester deasserting and reasserting in IDLE is treated as a new request.
//  Key latch: key_in changes after grant are ignored.
//   eng_in0/1 hold their value until the next grant.
//  rk_idx never exceeds 9; there is no wrap within a stream.
//  Throughput: 1 beat/cycle with rk_ready held high.
//   Total per grant = 1 (IDLE->RST) + 1 (RST) + engine latency + 10 beats.
//  NREQ=1: the rr pointer is constant 0.
// TESTING
//  1. Single req[0], key {input1,input0}=000102..1f, rk_ready=1.
//     -> k0..k9 on rk_idx 0..9 in 10 consecutive cycles, matching the
//        CryptoNight key schedule (k0=0f0e..00 word order); rk_last on idx 9.
//  2. req=4'b1111 held.
//     -> grant order 0,1,2,3,0; each stream completes before the next gnt;
//        gnt never multi-hot.
//  3. Backpressure: rk_ready toggles 1,0,0,1,...
//     -> rk_idx/rk_data stable while stalled; exactly 10 beats; no skip or
//        duplicate.
//  4. Engine model never asserts eng_done.
//     -> err pulses once, TIMEOUT cycles after WAIT entry, err_id=granted;
//        gnt drops; next requester granted.
//  5. req[granted] drops after 3 beats.
//     -> rk_valid low next cycle, state IDLE, no err, other requester granted.
//  6. rstn pulsed low mid-STREAM.
//     -> all outputs at reset values immediately (async), eng_rstn=0;
//        a fresh grant after release starts at rk_idx=0.

Source files
------------

// File: rtl/aes_genkey_arbiter_if.sv
// aes_genkey_arbiter_if: core-side stream bus and engine-side control bundle for the shared key-expansion arbiter
interface aes_genkey_arbiter_if #(parameter int NREQ = 4);
  logic [NREQ-1:0]     req;
  logic [NREQ-1:0]     gnt;
  logic [NREQ*256-1:0] key_in;
  logic                rk_valid;
  logic                rk_ready;
  logic [3:0]          rk_idx;
  logic [127:0]        rk_data;
  logic                rk_last;
  logic                err;
  logic [2:0]          err_id;
  logic                eng_rstn;
  logic [127:0]        eng_in0;
  logic [127:0]        eng_in1;
  logic                eng_done;
  logic [1279:0]       eng_k;
  modport master (
    output req, key_in, rk_ready, eng_done, eng_k,
    input  gnt, rk_valid, rk_idx, rk_data, rk_last, err, err_id, eng_rstn, eng_in0, eng_in1
  );
  modport slave (
    input  req, key_in, rk_ready, eng_done, eng_k,
    output gnt, rk_valid, rk_idx, rk_data, rk_last, err, err_id, eng_rstn, eng_in0, eng_in1
  );
endinterface

// File: rtl/aes_genkey_arbiter.sv
// aes_genkey_arbiter: round-robin sharing of one aes_genkey engine, streaming k0..k9 to the granted core
module aes_genkey_arbiter #(
  parameter int NREQ    = 4,
  parameter int TIMEOUT = 16
) (
  input logic clk,
  input logic rstn,
  aes_genkey_arbiter_if.slave bus
);
  localparam int TW = $clog2(TIMEOUT + 1);
  typedef enum logic [1:0] {IDLE, RST, WAIT, STREAM} state_t;
  state_t          state_q, state_d;
  logic [NREQ-1:0] gnt_q, gnt_d;
  logic [2:0]      gidx_q, gidx_d, ptr_q, ptr_d, err_id_q, err_id_d, win;
  logic [3:0]      idx_q, idx_d;
  logic [TW-1:0]   tmr_q, tmr_d;
  logic [127:0]    in0_q, in0_d, in1_q, in1_d;
  logic            err_q, err_d, held, hs;
  logic [255:0]    key_w;
  int              best, d;
  // winner is the requester with the smallest wrapped distance from the rr pointer
  always_comb begin
    win = '0;
    key_w = '0;
    best = NREQ;
    d = 0;
    for (int j = 0; j < NREQ; j++) begin
      d = (j + NREQ - int'(ptr_q)) % NREQ;
      if (bus.req[j] && d < best) begin
        best = d;
        win = 3'(j);
        key_w = bus.key_in[j*256 +: 256];
      end
    end
  end
  assign held = |(bus.req & gnt_q);
  assign hs   = (state_q == STREAM) && bus.rk_ready;
  always_comb begin
    state_d  = state_q;
    gnt_d    = gnt_q;
    gidx_d   = gidx_q;
    ptr_d    = ptr_q;
    idx_d    = idx_q;
    tmr_d    = tmr_q;
    in0_d    = in0_q;
    in1_d    = in1_q;
    err_d    = 1'b0;
    err_id_d = err_id_q;
    if (state_q == IDLE) begin
      if (|bus.req) begin
        state_d = RST;
        gnt_d   = NREQ'(1) << win;
        gidx_d  = win;
        ptr_d   = 3'((int'(win) + 1) % NREQ);
        in0_d   = key_w[127:0];
        in1_d   = key_w[255:128];
      end
    end else if (!held) begin
      state_d = IDLE;
      gnt_d   = '0;
      idx_d   = '0;
    end else if (state_q == RST) begin
      state_d = WAIT;
      tmr_d   = '0;
    end else if (state_q == WAIT) begin
      if (bus.eng_done) begin
        state_d = STREAM;
        idx_d   = '0;
      end else if (tmr_q == TW'(TIMEOUT - 1)) begin
        state_d  = IDLE;
        gnt_d    = '0;
        err_d    = 1'b1;
        err_id_d = gidx_q;
      end else begin
        tmr_d = tmr_q + TW'(1);
      end
    end else if (hs) begin
      state_d = (idx_q == 4'd9) ? IDLE : STREAM;
      gnt_d   = (idx_q == 4'd9) ? '0 : gnt_q;
      idx_d   = (idx_q == 4'd9) ? 4'd0 : idx_q + 4'd1;
    end
  end
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q  <= IDLE;
      gnt_q    <= '0;
      gidx_q   <= '0;
      ptr_q    <= '0;
      idx_q    <= '0;
      tmr_q    <= '0;
      in0_q    <= '0;
      in1_q    <= '0;
      err_q    <= 1'b0;
      err_id_q <= '0;
    end else begin
      state_q  <= state_d;
      gnt_q    <= gnt_d;
      gidx_q   <= gidx_d;
      ptr_q    <= ptr_d;
      idx_q    <= idx_d;
      tmr_q    <= tmr_d;
      in0_q    <= in0_d;
      in1_q    <= in1_d;
      err_q    <= err_d;
      err_id_q <= err_id_d;
    end
  end
  assign bus.gnt      = gnt_q;
  assign bus.rk_valid = state_q == STREAM;
  assign bus.rk_idx   = idx_q;
  assign bus.rk_last  = (state_q == STREAM) && (idx_q == 4'd9);
  assign bus.rk_data  = (state_q == STREAM) ? bus.eng_k[{idx_q, 7'd0} +: 128] : '0;
  assign bus.err      = err_q;
  assign bus.err_id   = err_id_q;
  assign bus.eng_rstn = (state_q == WAIT) || (state_q == STREAM);
  assign bus.eng_in0  = in0_q;
  assign bus.eng_in1  = in1_q;
endmodule

// File: tb/tb_aes_genkey_arbiter.sv
// tb_aes_genkey_arbiter: randomized scenario bench with a round-robin/stream reference model and a mock key engine
module tb_aes_genkey_arbiter;
  localparam int NREQ = 4, TIMEOUT = 16, LAT = 6;
  localparam logic [127:0] K0 = 128'h0f0e0d0c0b0a09080706050403020100;
  localparam logic [127:0] K1 = 128'h1f1e1d1c1b1a19181716151413121110;
  logic clk = 1'b0, rstn = 1'b0, eng_en = 1'b1;
  logic [255:0] kx [NREQ];
  int pass_n = 0, tot_n = 0, rptr = 0, ecnt = 0;
  always #5 clk = ~clk;
  aes_genkey_arbiter_if #(.NREQ(NREQ)) bus ();
  aes_genkey_arbiter #(.NREQ(NREQ), .TIMEOUT(TIMEOUT)) dut (.clk(clk), .rstn(rstn), .bus(bus));
  // mock schedule: k0/k1 are the key halves, later keys mix the previous two
  function automatic logic [127:0] kref(input logic [255:0] k, input int i);
    logic [127:0] a, b, c;
    a = k[127:0];
    b = k[255:128];
    for (int n = 2; n <= i; n++) begin
      c = a ^ {b[95:0], b[127:96]} ^ 128'(n);
      a = b;
      b = c;
    end
    return (i == 0) ? a : b;
  endfunction
  function automatic int rr_pick(input logic [NREQ-1:0] r);
    for (int i = 0; i < NREQ; i++) if (r[(rptr + i) % NREQ]) return (rptr + i) % NREQ;
    return -1;
  endfunction
  for (genvar g = 0; g < NREQ; g++) assign bus.key_in[g*256 +: 256] = kx[g];
  for (genvar g = 0; g < 10; g++) assign bus.eng_k[g*128 +: 128] = kref({bus.eng_in1, bus.eng_in0}, g);
  always @(negedge clk) begin
    ecnt = bus.eng_rstn ? ecnt + 1 : 0;
    bus.eng_done = eng_en && ecnt >= LAT;
  end
  initial begin
    #500000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end
  task automatic apply_reset();
    rstn = 1'b0;
    bus.req = '0;
    bus.rk_ready = 1'b0;
    eng_en = 1'b1;
    for (int i = 0; i < NREQ; i++) kx[i] = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    rptr = 0;
    repeat (3) @(negedge clk);
    rstn = 1'b1;
  endtask
  task automatic test_reset();
    rstn = 1'b0;
    bus.req = '1;
    bus.rk_ready = 1'b1;
    for (int i = 0; i < NREQ; i++) kx[i] = {8{$urandom}};
    repeat (2) @(negedge clk);
    tot_n++; if ({bus.gnt, bus.rk_valid, bus.rk_idx, bus.rk_last, bus.err, bus.err_id, bus.eng_rstn} !== '0)
      $display("FAIL rst_ctrl: got gnt=%0h v=%0b idx=%0d err=%0b eng_rstn=%0b want 0", bus.gnt, bus.rk_valid, bus.rk_idx, bus.err, bus.eng_rstn); else pass_n++;
    tot_n++; if (bus.rk_data !== '0) $display("FAIL rst_data: got %0h want 0", bus.rk_data); else pass_n++;
    tot_n++; if ({bus.eng_in1, bus.eng_in0} !== '0) $display("FAIL rst_engin: got %0h want 0", {bus.eng_in1, bus.eng_in0}); else pass_n++;
    bus.req = '0;
    rstn = 1'b1;
    repeat (2) @(negedge clk);
    tot_n++; if ({bus.gnt, bus.rk_valid, bus.eng_rstn} !== '0) $display("FAIL rst_idle: got gnt=%0h eng_rstn=%0b want 0", bus.gnt, bus.eng_rstn); else pass_n++;
  endtask
  task automatic test_single();
    int g0, first, lastc, beat;
    bit fin;
    apply_reset();
    kx[0] = {K1, K0};
    bus.req = 4'b0001;
    bus.rk_ready = 1'b1;
    g0 = -1; first = -1; lastc = -1; beat = 0; fin = 0;
    for (int c = 0; c < 60 && !fin; c++) begin
      @(negedge clk);
      if (beat == 10) begin
        tot_n++; if ({bus.gnt, bus.rk_valid} !== '0) $display("FAIL single_end: got gnt=%0h v=%0b want 0", bus.gnt, bus.rk_valid); else pass_n++;
        bus.req = '0;
        fin = 1;
      end else begin
        if (g0 < 0 && bus.gnt !== '0) begin
          g0 = c;
          rptr = 1;
          tot_n++; if ({bus.gnt, bus.eng_in1, bus.eng_in0} !== {4'b0001, K1, K0})
            $display("FAIL single_grant: got gnt=%0h in1=%0h in0=%0h want 1 %0h %0h", bus.gnt, bus.eng_in1, bus.eng_in0, K1, K0); else pass_n++;
        end
        if (bus.rk_valid) begin
          if (first < 0) first = c;
          if (beat == 0) begin
            tot_n++; if (bus.rk_data !== K0) $display("FAIL single_k0: got %0h want %0h", bus.rk_data, K0); else pass_n++;
          end
          tot_n++; if ({bus.rk_idx, bus.rk_last, bus.rk_data} !== {4'(beat), beat == 9, kref({K1, K0}, beat)})
            $display("FAIL single_beat: got idx=%0d last=%0b data=%0h want idx=%0d", bus.rk_idx, bus.rk_last, bus.rk_data, beat); else pass_n++;
          beat++;
          lastc = c;
        end
      end
    end
    tot_n++; if (!fin) $display("FAIL single_done: got beats=%0d want 10", beat); else pass_n++;
    tot_n++; if (first - g0 != LAT + 1) $display("FAIL single_latency: got %0d want %0d", first - g0, LAT + 1); else pass_n++;
    tot_n++; if (lastc - first != 9) $display("FAIL single_consecutive: got %0d want 9", lastc - first); else pass_n++;
  endtask
  task automatic test_round_robin();
    int w, beat, got;
    int order[$];
    int expo[5] = '{0, 1, 2, 3, 0};
    bit wait_idle;
    logic [255:0] lk;
    apply_reset();
    bus.req = '1;
    bus.rk_ready = 1'b1;
    w = -1; beat = 0; got = 0; wait_idle = 0; lk = '0;
    for (int c = 0; c < 300 && got < 5; c++) begin
      @(negedge clk);
      if (wait_idle) begin
        tot_n++; if ({bus.gnt, bus.rk_valid} !== '0) $display("FAIL rr_gap: got gnt=%0h v=%0b want 0", bus.gnt, bus.rk_valid); else pass_n++;
        wait_idle = 0; w = -1; got++;
      end else if (w < 0 && bus.gnt !== '0) begin
        w = rr_pick(bus.req);
        rptr = (w + 1) % NREQ;
        lk = kx[w];
        beat = 0;
        order.push_back(w);
      end
      if (w >= 0 && !wait_idle) begin
        tot_n++; if (bus.gnt !== NREQ'(1) << w) $display("FAIL rr_gnt: got %0h want %0h", bus.gnt, NREQ'(1) << w); else pass_n++;
      end
      if (bus.rk_valid) begin
        tot_n++; if ({bus.rk_idx, bus.rk_last, bus.rk_data} !== {4'(beat), beat == 9, kref(lk, beat)})
          $display("FAIL rr_beat: got idx=%0d data=%0h want idx=%0d data=%0h", bus.rk_idx, bus.rk_data, beat, kref(lk, beat)); else pass_n++;
        beat++;
        if (beat == 10) wait_idle = 1;
      end
    end
    tot_n++; if (order.size() != 5) $display("FAIL rr_count: got %0d want 5", order.size()); else pass_n++;
    for (int i = 0; i < order.size() && i < 5; i++) begin
      tot_n++; if (order[i] != expo[i]) $display("FAIL rr_order: got %0d want %0d at %0d", order[i], expo[i], i); else pass_n++;
    end
  endtask
  task automatic test_backpressure();
    int w, beat, g, sc;
    bit wait_idle;
    logic [255:0] lk;
    apply_reset();
    bus.req = 4'b0101;
    w = -1; beat = 0; g = 0; sc = 0; wait_idle = 0; lk = '0;
    for (int c = 0; c < 300 && g < 2; c++) begin
      @(negedge clk);
      if (wait_idle) begin
        tot_n++; if ({bus.gnt, bus.rk_valid} !== '0) $display("FAIL bp_end: got gnt=%0h v=%0b want 0", bus.gnt, bus.rk_valid); else pass_n++;
        wait_idle = 0; w = -1; g++;
      end else if (w < 0 && bus.gnt !== '0) begin
        w = rr_pick(bus.req);
        rptr = (w + 1) % NREQ;
        lk = kx[w];
        kx[w] = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
        beat = 0; sc = 0;
        tot_n++; if (bus.gnt !== NREQ'(1) << w) $display("FAIL bp_gnt: got %0h want %0h", bus.gnt, NREQ'(1) << w); else pass_n++;
      end
      bus.rk_ready = (g == 0) ? (sc % 3 == 0) : 1'($urandom_range(0, 1));
      if (bus.rk_valid) begin
        tot_n++; if ({bus.rk_idx, bus.rk_last, bus.rk_data, bus.eng_in0} !== {4'(beat), beat == 9, kref(lk, beat), lk[127:0]})
          $display("FAIL bp_beat: got idx=%0d data=%0h want idx=%0d data=%0h", bus.rk_idx, bus.rk_data, beat, kref(lk, beat)); else pass_n++;
        sc++;
        if (bus.rk_ready) begin
          beat++;
          if (beat == 10) wait_idle = 1;
        end
      end
    end
    tot_n++; if (g != 2) $display("FAIL bp_grants: got %0d want 2", g); else pass_n++;
  endtask
  task automatic test_timeout();
    int w, t, nerr, g2, post;
    apply_reset();
    eng_en = 1'b0;
    bus.req = 4'b0011;
    bus.rk_ready = 1'b1;
    w = -1; t = -1; nerr = 0; g2 = -1; post = 0;
    for (int c = 0; c < 120 && post < 10; c++) begin
      @(negedge clk);
      if (t >= 0) t++;
      else if (bus.eng_rstn && nerr == 0) t = 0;
      if (w < 0 && bus.gnt !== '0) begin
        w = rr_pick(bus.req);
        rptr = (w + 1) % NREQ;
        if (nerr > 0) g2 = w;
        tot_n++; if (bus.gnt !== NREQ'(1) << w) $display("FAIL to_gnt: got %0h want %0h", bus.gnt, NREQ'(1) << w); else pass_n++;
      end
      if (bus.err) begin
        nerr++;
        tot_n++; if (t != TIMEOUT) $display("FAIL to_delay: got %0d want %0d", t, TIMEOUT); else pass_n++;
        tot_n++; if (bus.err_id !== 3'(w)) $display("FAIL to_err_id: got %0d want %0d", bus.err_id, w); else pass_n++;
        tot_n++; if (bus.gnt !== '0) $display("FAIL to_gnt_drop: got %0h want 0", bus.gnt); else pass_n++;
        t = -1000;
        w = -1;
      end
      if (g2 >= 0) post++;
    end
    tot_n++; if (nerr != 1) $display("FAIL to_err_count: got %0d want 1", nerr); else pass_n++;
    tot_n++; if (g2 != 1) $display("FAIL to_next_gnt: got %0d want 1", g2); else pass_n++;
    bus.req = '0;
    eng_en = 1'b1;
  endtask
  task automatic test_abort();
    int w, beat, ph, w2;
    apply_reset();
    bus.req = 4'b1001;
    bus.rk_ready = 1'b1;
    w = -1; beat = 0; ph = 0; w2 = -1;
    for (int c = 0; c < 120 && ph < 5; c++) begin
      @(negedge clk);
      tot_n++; if (bus.err !== 1'b0) $display("FAIL ab_err: got 1 want 0"); else pass_n++;
      if (ph == 0) begin
        if (bus.gnt !== '0) begin
          w = rr_pick(bus.req);
          rptr = (w + 1) % NREQ;
          ph = 1;
          tot_n++; if (bus.gnt !== NREQ'(1) << w) $display("FAIL ab_gnt: got %0h want %0h", bus.gnt, NREQ'(1) << w); else pass_n++;
        end
      end else if (ph == 1) begin
        if (bus.rk_valid) begin
          tot_n++; if ({bus.rk_idx, bus.rk_data} !== {4'(beat), kref(kx[w], beat)})
            $display("FAIL ab_beat: got idx=%0d want %0d", bus.rk_idx, beat); else pass_n++;
          beat++;
          if (beat == 3) ph = 2;
        end
      end else if (ph == 2) begin
        tot_n++; if ({bus.rk_valid, bus.rk_idx} !== {1'b1, 4'd3}) $display("FAIL ab_hold: got v=%0b idx=%0d want 1 3", bus.rk_valid, bus.rk_idx); else pass_n++;
        bus.req[w] = 1'b0;
        bus.rk_ready = 1'b0;
        ph = 3;
      end else if (ph == 3) begin
        tot_n++; if ({bus.gnt, bus.rk_valid, bus.rk_idx, bus.eng_rstn} !== '0)
          $display("FAIL ab_idle: got gnt=%0h v=%0b idx=%0d eng_rstn=%0b want 0", bus.gnt, bus.rk_valid, bus.rk_idx, bus.eng_rstn); else pass_n++;
        ph = 4;
      end else begin
        w2 = rr_pick(bus.req);
        tot_n++; if (bus.gnt !== 4'b1000 || w2 != 3) $display("FAIL ab_regrant: got %0h want 8", bus.gnt); else pass_n++;
        ph = 5;
      end
    end
    tot_n++; if (ph != 5) $display("FAIL ab_done: got phase %0d want 5", ph); else pass_n++;
    bus.req = '0;
  endtask
  task automatic test_async_reset();
    int w, beat, c0;
    bit hit;
    apply_reset();
    bus.req = 4'b0110;
    bus.rk_ready = 1'b1;
    hit = 0;
    for (int c = 0; c < 60 && !hit; c++) begin
      @(negedge clk);
      if (bus.rk_valid && bus.rk_idx == 4'd4) hit = 1;
    end
    tot_n++; if (!hit) $display("FAIL ar_reach: got no beat 4 want beat 4"); else pass_n++;
    #2 rstn = 1'b0;
    #1;
    tot_n++; if ({bus.gnt, bus.rk_valid, bus.rk_idx, bus.rk_last, bus.err, bus.eng_rstn} !== '0)
      $display("FAIL ar_ctrl: got gnt=%0h v=%0b idx=%0d eng_rstn=%0b want 0", bus.gnt, bus.rk_valid, bus.rk_idx, bus.eng_rstn); else pass_n++;
    tot_n++; if ({bus.rk_data, bus.eng_in0, bus.eng_in1} !== '0) $display("FAIL ar_data: got %0h want 0", bus.rk_data); else pass_n++;
    rptr = 0;
    @(negedge clk);
    rstn = 1'b1;
    w = -1; beat = 0; c0 = 0;
    for (int c = 0; c < 80 && beat < 10; c++) begin
      @(negedge clk);
      if (w < 0 && bus.gnt !== '0) begin
        w = rr_pick(bus.req);
        rptr = (w + 1) % NREQ;
        tot_n++; if (bus.gnt !== NREQ'(1) << w) $display("FAIL ar_gnt: got %0h want %0h", bus.gnt, NREQ'(1) << w); else pass_n++;
      end
      bus.rk_ready = 1'($urandom_range(0, 1));
      if (bus.rk_valid) begin
        tot_n++; if ({bus.rk_idx, bus.rk_data} !== {4'(beat), kref(kx[w], beat)})
          $display("FAIL ar_beat: got idx=%0d want %0d", bus.rk_idx, beat); else pass_n++;
        if (bus.rk_ready) beat++;
        c0++;
      end
    end
    tot_n++; if (beat != 10) $display("FAIL ar_stream: got %0d beats want 10", beat); else pass_n++;
    bus.req = '0;
  endtask
  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_backpressure();
    test_timeout();
    test_abort();
    test_async_reset();
    $display("%0d/%0d checks passed", pass_n, tot_n);
    $finish;
  end
endmodule
